// File: rtl/up_counter_pkg.sv
// Shared types and next-count helper for the enable-gated up counter.
// Build option UP_COUNTER_SATURATE_EN is resolved in up_counter_next.
package up_counter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [DEFAULT_WIDTH-1:0] count_t;

  typedef struct packed {
    count_t value;
    logic   changed;
  } next_t;

  // Step from cur toward max; at max either wrap to zero or hold (no change).
  function automatic next_t next_count(input count_t cur, input count_t max, input logic saturate);
    next_t r;
    r.value   = cur;
    r.changed = 1'b0;
    if (cur < max) begin
      r.value   = cur + count_t'(1);
      r.changed = 1'b1;
    end else if (saturate) begin
      r.value   = cur;
      r.changed = 1'b0;
    end else begin
      r.value   = {DEFAULT_WIDTH{1'b0}};
      r.changed = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/up_counter_next.sv
// Combinational next-count and changed-flag logic (wrap or saturate at max).
// Saturation is selected by defining UP_COUNTER_SATURATE_EN.
module up_counter_next
  import up_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] nxt,
  output logic             changed
);

`ifdef UP_COUNTER_SATURATE_EN
  localparam logic SATURATE = 1'b1;
`else
  localparam logic SATURATE = 1'b0;
`endif

  generate
    if (WIDTH == DEFAULT_WIDTH) begin : g_pkg
      next_t nxt_s;

      // Default width reuses the shared helper directly.
      always_comb begin
        nxt_s   = next_count(count_t'(cur), count_t'(max), SATURATE);
        nxt     = nxt_s.value;
        changed = nxt_s.changed;
      end
    end else begin : g_generic
      // Same rule as next_count, sized to WIDTH.
      always_comb begin
        nxt     = cur;
        changed = 1'b0;
        if (cur < max) begin
          nxt     = cur + {{(WIDTH-1){1'b0}}, 1'b1};
          changed = 1'b1;
        end else if (SATURATE) begin
          nxt     = cur;
          changed = 1'b0;
        end else begin
          nxt     = {WIDTH{1'b0}};
          changed = 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/up_counter_valid.sv
// Enable-gated up counter with registered count and one-cycle update strobe.
// Define UP_COUNTER_SATURATE_EN to hold at MAX_COUNT instead of wrapping.
module up_counter_valid
  import up_counter_pkg::*;
#(
  parameter int          WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned MAX_COUNT = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [WIDTH-1:0] out,
  output logic             valid1
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] out_r;
  logic             valid1_r;
  logic [WIDTH-1:0] nxt_s;
  logic             changed_s;

  up_counter_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .cur    (out_r),
    .max    (MAX_C),
    .nxt    (nxt_s),
    .changed(changed_s)
  );

  // Count/strobe registers; reset wins, and only a clean 1 on enable advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r    <= {WIDTH{1'b0}};
      valid1_r <= 1'b0;
    end else if (enable == 1'b1) begin
      out_r    <= nxt_s;
      valid1_r <= changed_s;
    end else begin
      out_r    <= out_r;
      valid1_r <= 1'b0;
    end
  end

  assign out    = out_r;
  assign valid1 = valid1_r;

endmodule

// File: tb/tb_up_counter_valid.sv
// Self-checking bench for up_counter_valid: directed table, corner sequences,
// and randomized stimulus against an arithmetic reference model.
module tb_up_counter_valid;

`ifdef UP_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam int MAXA = 255;
  localparam int MAXB = 9;

  logic       clk = 1'b0;
  logic       rst, enable, rst9, enable9;
  logic [7:0] out, out9;
  logic       valid1, valid1_9;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_out = 0, m_v = 0, m9_out = 0, m9_v = 0;

  up_counter_valid dut (
    .clk(clk), .rst(rst), .enable(enable), .out(out), .valid1(valid1)
  );

  up_counter_valid #(.WIDTH(8), .MAX_COUNT(MAXB)) dut9 (
    .clk(clk), .rst(rst9), .enable(enable9), .out(out9), .valid1(valid1_9)
  );

  always #2 clk = ~clk;

  typedef struct {
    logic r;
    logic e;
    int   exp_out;
    int   exp_v;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model(input logic r, input logic e, input int max, inout int mo, inout int mv);
    if (r === 1'b1) begin
      mo = 0; mv = 0;
    end else if (e === 1'b1) begin
      if (SAT && mo == max) mv = 0;
      else begin mo = (mo + 1) % (max + 1); mv = 1; end
    end else begin
      mv = 0;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic r9, input logic e9);
    @(negedge clk);
    rst = r; enable = e; rst9 = r9; enable9 = e9;
    @(posedge clk);
    model(r, e, MAXA, m_out, m_v);
    model(r9, e9, MAXB, m9_out, m9_v);
    #1;
  endtask

  vec_t tbl[10];

  initial begin
    rst = 1'b1; enable = 1'b0; rst9 = 1'b1; enable9 = 1'b0;
    for (int i = 0; i < 7; i++) tbl[i] = '{1'b0, 1'b1, i + 1, 1};
    tbl[7] = '{1'b0, 1'b0, 7, 0};
    tbl[8] = '{1'b0, 1'b0, 7, 0};
    tbl[9] = '{1'b0, 1'b1, 8, 1};

    // reset edge, then undriven enable
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("reset_out", int'(out), 0);
    chk("reset_valid", int'(valid1), 0);
    step(1'b0, 1'bx, 1'b1, 1'b0);
    chk("xen_out", int'(out), 0);
    chk("xen_valid", int'(valid1), 0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].e, 1'b1, 1'b0);
      chk($sformatf("tbl%0d_out", i), int'(out), tbl[i].exp_out);
      chk($sformatf("tbl%0d_valid", i), int'(valid1), tbl[i].exp_v);
    end

    // preload to terminal value, then one more enabled edge
    for (int i = 0; i < 247; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("at_max_out", int'(out), 255);
    chk("at_max_valid", int'(valid1), 1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("past_max_out", int'(out), SAT ? 255 : 0);
    chk("past_max_valid", int'(valid1), SAT ? 0 : 1);

    // reset has priority over enable mid-count
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("pre_rst_out", int'(out), 5);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_en_out", int'(out), 0);
    chk("rst_en_valid", int'(valid1), 0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("rel_out", int'(out), 1);
    chk("rel_valid", int'(valid1), 1);

    // MAX_COUNT=9 instance
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("m9_reset_out", int'(out9), 0);
    for (int i = 1; i <= 11; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk($sformatf("m9_e%0d_out", i), int'(out9), SAT ? ((i > 9) ? 9 : i) : (i % 10));
      chk($sformatf("m9_e%0d_valid", i), int'(valid1_9), SAT ? ((i <= 9) ? 1 : 0) : 1);
    end

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(15) == 0), $urandom_range(3) != 0,
           ($urandom_range(31) == 0), $urandom_range(3) != 0);
      chk("rnd_out", int'(out), m_out);
      chk("rnd_valid", int'(valid1), m_v);
      chk("rnd9_out", int'(out9), m9_out);
      chk("rnd9_valid", int'(valid1_9), m9_v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
